// File: rtl/wb_pkg.sv
// Shared widths, source-select codes, occupancy states and buffer entry type
// for the writeback port arbiter.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   localparam logic WB_SRC_ALU = 1'b0;
   localparam logic WB_SRC_MEM = 1'b1;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PENDING = 2'd1,
      ST_FULL    = 2'd2
   } wbState_e;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wbEntry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order holding buffer for deferred ALU results, with a per-slot rd match
// vector. Building with WB_FWD_EN adds a youngest-match forwarding lookup.
module wb_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic [ADDR_W-1:0]       pushRd,
   input  logic [DATA_W-1:0]       pushData,
   input  logic [ADDR_W-1:0]       queryRd,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic [ADDR_W-1:0]       headRd,
   output logic [DATA_W-1:0]       headData,
   output logic [DEPTH-1:0]        matchVec
`ifdef WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0]       fwdRs,
   output logic                    fwdHit,
   output logic [DATA_W-1:0]       fwdData
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [ADDR_W-1:0] rdMem   [DEPTH];
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [DEPTH-1:0]  slotValid;

   // Pointers carry one extra wrap bit so full and empty stay distinguishable.
   assign count    = wrPtr - rdPtr;
   assign empty    = (wrPtr == rdPtr);
   assign full     = ((wrPtr ^ rdPtr) == {1'b1, {IDX_W{1'b0}}});
   assign headRd   = rdMem[rdPtr[IDX_W-1:0]];
   assign headData = dataMem[rdPtr[IDX_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rdMem[wrPtr[IDX_W-1:0]]   <= pushRd;
         dataMem[wrPtr[IDX_W-1:0]] <= pushData;
      end
   end

   // A slot is live when its distance from the head is below the occupancy.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
      logic [IDX_W-1:0] age;
      assign age           = IDX_W'(gi) - rdPtr[IDX_W-1:0];
      assign slotValid[gi] = ({1'b0, age} < count);
      assign matchVec[gi]  = slotValid[gi] && (rdMem[gi] == queryRd);
   end

`ifdef WB_FWD_EN
   logic [IDX_W-1:0] fwdSlot;

   // Walk oldest to youngest so the last hit is the most recent value.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      fwdSlot = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwdSlot = rdPtr[IDX_W-1:0] + IDX_W'(k);
         if (slotValid[fwdSlot] && (fwdRs != '0) && (rdMem[fwdSlot] == fwdRs)) begin
            fwdHit  = 1'b1;
            fwdData = dataMem[fwdSlot];
         end
      end
   end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between load returns and ALU results,
// deferring losing ALU results in wb_fifo. WB_FWD_EN exposes a buffer forwarding port.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   output logic              alu_stall,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              wb_src
`ifdef WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0] fwd_rs,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   wbState_e          stateReg;
   wbState_e          stateNext;

   logic              aluAcc;
   logic              ldLive;
   logic              squash;
   logic              ldWin;
   logic              popHead;
   logic              bypass;
   logic              push;

   logic              fifoEmpty;
   logic              fifoFull;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  countNext;
   logic [ADDR_W-1:0] headRd;
   logic [DATA_W-1:0] headData;
   logic [DEPTH-1:0]  ldMatch;

   logic              weNext;
   logic              srcNext;
   logic [ADDR_W-1:0] addrNext;
   logic [DATA_W-1:0] dataNext;

   wb_fifo #(
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) uFifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (popHead),
      .pushRd   (alu_rd),
      .pushData (alu_data),
      .queryRd  (ld_rd),
      .empty    (fifoEmpty),
      .full     (fifoFull),
      .count    (count),
      .headRd   (headRd),
      .headData (headData),
      .matchVec (ldMatch)
`ifdef WB_FWD_EN
      ,
      .fwdRs    (fwd_rs),
      .fwdHit   (fwd_hit),
      .fwdData  (fwd_data)
`endif
   );

   // A load is older than anything buffered or arriving alongside it, so any
   // younger write to the same rd makes the load value dead.
   always_comb begin
      aluAcc   = alu_valid && !alu_stall && (alu_rd != '0);
      ldLive   = ld_valid && (ld_rd != '0);
      squash   = ldLive && ((|ldMatch) || (aluAcc && (alu_rd == ld_rd)));
      ldWin    = ldLive && !squash;
      popHead  = !ldWin && !fifoEmpty;
      bypass   = !ldWin && fifoEmpty && aluAcc;
      push     = aluAcc && !bypass && !fifoFull;

      weNext   = 1'b0;
      srcNext  = wb_src;
      addrNext = rf_waddr;
      dataNext = rf_wdata;
      if (ldWin) begin
         weNext   = 1'b1;
         srcNext  = WB_SRC_MEM;
         addrNext = ld_rd;
         dataNext = ld_data;
      end else if (popHead) begin
         weNext   = 1'b1;
         srcNext  = WB_SRC_ALU;
         addrNext = headRd;
         dataNext = headData;
      end else if (bypass) begin
         weNext   = 1'b1;
         srcNext  = WB_SRC_ALU;
         addrNext = alu_rd;
         dataNext = alu_data;
      end
   end

   assign countNext = count + CNT_W'(push) - CNT_W'(popHead);

   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         ST_EMPTY: begin
            if (push && !popHead) stateNext = ST_PENDING;
         end
         ST_PENDING: begin
            if (countNext == CNT_W'(DEPTH))  stateNext = ST_FULL;
            else if (countNext == '0)        stateNext = ST_EMPTY;
         end
         ST_FULL: begin
            if (popHead) stateNext = ST_PENDING;
         end
         default: stateNext = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg  <= ST_EMPTY;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         wb_src    <= WB_SRC_ALU;
         alu_stall <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         rf_we     <= weNext;
         rf_waddr  <= addrNext;
         rf_wdata  <= dataNext;
         wb_src    <= srcNext;
         alu_stall <= (stateNext == ST_FULL);
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed scoreboard bench for wb_port_arbiter against a
// queue-based reference model of the writeback arbitration rules.
module tb_wb_port_arbiter;
   import wb_pkg::*;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              src;
   } expWrite_t;

   logic              clk;
   logic              rst_n;
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              ld_valid;
   logic [ADDR_W-1:0] ld_rd;
   logic [DATA_W-1:0] ld_data;
   logic              alu_stall;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              wb_src;
`ifdef WB_FWD_EN
   logic [ADDR_W-1:0] fwd_rs;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
`endif

   int                checks   = 0;
   int                failures = 0;
   int                cyc      = 0;

   wbEntry_t          bufQ[$];
   expWrite_t         expQ[$];
   logic [ADDR_W-1:0] lastAddr = '0;
   logic [DATA_W-1:0] lastData = '0;
   logic              lastSrc  = 1'b0;

   wb_port_arbiter #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .alu_stall (alu_stall),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .wb_src    (wb_src)
`ifdef WB_FWD_EN
      ,
      .fwd_rs    (fwd_rs),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever @(posedge clk) cyc++;

   function automatic void expWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic s);
      expWrite_t w;
      w.cyc  = cyc + 1;
      w.addr = a;
      w.data = d;
      w.src  = s;
      expQ.push_back(w);
   endfunction

   // One cycle of stimulus; the model decides the winner from the arbitration rules.
   task automatic doCycle(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat,
                          input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldat);
      bit       modelStall;
      bit       aluAcc;
      bit       ldLive;
      bit       squash;
      wbEntry_t e;
      @(posedge clk);
      #1;
      modelStall = (bufQ.size() == DEPTH);
      checks++;
      if (alu_stall !== modelStall) begin
         failures++;
         $display("FAIL alu_stall cyc=%0d got=%b required=%b", cyc, alu_stall, modelStall);
      end
      alu_valid = av;  alu_rd = ard;  alu_data = adat;
      ld_valid  = lv;  ld_rd  = lrd;  ld_data  = ldat;

      aluAcc = av && !modelStall && (ard != 0);
      ldLive = lv && (lrd != 0);
      squash = 1'b0;
      if (ldLive) begin
         if (aluAcc && ard == lrd) squash = 1'b1;
         foreach (bufQ[k]) if (bufQ[k].rd == lrd) squash = 1'b1;
      end
      e.rd   = ard;
      e.data = adat;
      if (ldLive && !squash) begin
         expWrite(lrd, ldat, WB_SRC_MEM);
         if (aluAcc) bufQ.push_back(e);
      end else if (bufQ.size() > 0) begin
         wbEntry_t h;
         h = bufQ.pop_front();
         expWrite(h.rd, h.data, WB_SRC_ALU);
         if (aluAcc) bufQ.push_back(e);
      end else if (aluAcc) begin
         expWrite(ard, adat, WB_SRC_ALU);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) doCycle(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checks++;
      if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || wb_src !== 1'b0 || alu_stall !== 1'b0) begin
         failures++;
         $display("FAIL %s got we=%b addr=%0d data=%h src=%b stall=%b required all zero",
                  tag, rf_we, rf_waddr, rf_wdata, wb_src, alu_stall);
      end
   endtask

   task automatic midReset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      #1;
      checkResetOutputs("reset_mid_drain");
      bufQ.delete();
      expQ.delete();
      lastAddr = '0;
      lastData = '0;
      lastSrc  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: pops an expected write whenever the DUT presents rf_we.
   initial begin
      expWrite_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rf_we) begin
               checks++;
               if (expQ.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h src=%b required no write",
                           cyc, rf_waddr, rf_wdata, wb_src);
               end else begin
                  e = expQ.pop_front();
                  if (e.cyc != cyc || rf_waddr !== e.addr || rf_wdata !== e.data || wb_src !== e.src) begin
                     failures++;
                     $display("FAIL write cyc=%0d got addr=%0d data=%h src=%b required cyc=%0d addr=%0d data=%h src=%b",
                              cyc, rf_waddr, rf_wdata, wb_src, e.cyc, e.addr, e.data, e.src);
                  end
                  lastAddr = e.addr;
                  lastData = e.data;
                  lastSrc  = e.src;
               end
            end else begin
               checks++;
               if (rf_waddr !== lastAddr || rf_wdata !== lastData || wb_src !== lastSrc) begin
                  failures++;
                  $display("FAIL idle_hold cyc=%0d got addr=%0d data=%h src=%b required addr=%0d data=%h src=%b",
                           cyc, rf_waddr, rf_wdata, wb_src, lastAddr, lastData, lastSrc);
               end
               if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                  e = expQ.pop_front();
                  checks++;
                  failures++;
                  $display("FAIL missing_write cyc=%0d got rf_we=0 required addr=%0d data=%h src=%b",
                           cyc, e.addr, e.data, e.src);
               end
            end
         end
      end
   end

   initial begin
      logic              av;
      logic [ADDR_W-1:0] ard;
      logic [DATA_W-1:0] adat;
      int                ldPct;

      rst_n = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
`ifdef WB_FWD_EN
      fwd_rs = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset_initial");
      rst_n = 1'b1;

      // ALU only: bypass write
      doCycle(1'b1, 5'd5, 32'h11, 1'b0, '0, '0);
      idle(2);
      // Collision: load first, ALU next cycle
      doCycle(1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA);
      idle(3);
      // Fill: four load/ALU collisions then drain
      for (int k = 0; k < DEPTH; k++)
         doCycle(1'b1, 5'(10 + k), 32'h100 + k, 1'b1, 5'(20 + k), 32'h200 + k);
      idle(DEPTH + 2);
      // Squash: buffered rd=7 kills an older load to rd=7
      doCycle(1'b1, 5'd7, 32'h55, 1'b1, 5'd8, 32'h66);
      doCycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h99);
      idle(2);
      // x0 inputs are dropped
      doCycle(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'h12);
      idle(2);
      // Same-cycle ALU to the load's rd squashes the load
      doCycle(1'b1, 5'd9, 32'hC0DE, 1'b1, 5'd9, 32'hDEAD);
      idle(2);
      // Reset mid-drain with three entries buffered
      for (int k = 0; k < 3; k++)
         doCycle(1'b1, 5'(11 + k), 32'h300 + k, 1'b1, 5'(21 + k), 32'h400 + k);
      midReset();
      idle(4);

      // Randomized phases alternating light and heavy load traffic
      av = 1'b0; ard = '0; adat = '0;
      for (int i = 0; i < 600; i++) begin
         ldPct = ((i / 40) % 2 == 1) ? 85 : 30;
         if (!(av && bufQ.size() == DEPTH)) begin
            av   = ($urandom_range(0, 99) < 65);
            ard  = 5'($urandom_range(0, 7));
            adat = $urandom;
         end
         doCycle(av, ard, adat, ($urandom_range(0, 99) < ldPct), 5'($urandom_range(0, 7)), $urandom);
      end
      idle(DEPTH + 3);

      @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("FAIL drain_empty got pending=%0d required 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
